// File: rtl/mult_div_unit.sv
// +----------------------------------------------------------------------------+
// | mult_div_unit : E-stage multiply/divide unit with HI/LO and busy counter   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  mdu_type,
  input  logic        cancel,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] result
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  logic [3:0]  cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_we;
  logic        accept;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] quot_s;
  logic [31:0] rem_s;
  logic [31:0] quot_u;
  logic [31:0] rem_u;
  logic        div_zero;

  assign accept   = start && !cancel && !busy;
  assign div_zero = (rt_val == 32'd0);

  assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // Zero divisor and the single signed overflow case are resolved here so
  // the divider never sees an undefined operand pair.
  always_comb begin
    quot_s = 32'd0;
    rem_s  = 32'd0;
    quot_u = 32'd0;
    rem_u  = 32'd0;
    if (!div_zero) begin
      if (rs_val == 32'h8000_0000 && rt_val == 32'hFFFF_FFFF) begin
        quot_s = 32'h8000_0000;
        rem_s  = 32'd0;
      end else begin
        quot_s = $signed(rs_val) / $signed(rt_val);
        rem_s  = $signed(rs_val) % $signed(rt_val);
      end
      quot_u = rs_val / rt_val;
      rem_u  = rs_val % rt_val;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi      <= 32'd0;
      lo      <= 32'd0;
      busy    <= 1'b0;
      cnt     <= 4'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_we <= 1'b0;
    end else if (accept) begin
      case (mdu_type)
        OP_MULT, OP_MULTU: begin
          pend_hi <= (mdu_type == OP_MULT) ? prod_s[63:32] : prod_u[63:32];
          pend_lo <= (mdu_type == OP_MULT) ? prod_s[31:0]  : prod_u[31:0];
          pend_we <= 1'b1;
          cnt     <= MULT_CNT;
          busy    <= 1'b1;
        end
        OP_DIV, OP_DIVU: begin
          pend_hi <= (mdu_type == OP_DIV) ? rem_s  : rem_u;
          pend_lo <= (mdu_type == OP_DIV) ? quot_s : quot_u;
          pend_we <= !div_zero;
          cnt     <= DIV_CNT;
          busy    <= 1'b1;
        end
        OP_MTHI: hi <= rs_val;
        OP_MTLO: lo <= rs_val;
        default: ;
      endcase
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        busy <= 1'b0;
        if (pend_we) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
      end
    end
  end

  always_comb begin
    result = 32'd0;
    if (mdu_type == OP_MFHI)      result = hi;
    else if (mdu_type == OP_MFLO) result = lo;
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// +----------------------------------------------------------------------------+
// | tb_mult_div_unit : directed vector bench for mult_div_unit                 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  mdu_type = 4'd0;
  logic        cancel = 1'b0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .mdu_type (mdu_type),
    .cancel   (cancel),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo),
    .result   (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          cyc;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op (accepted at the next rising edge), then count busy cycles
  // while checking that HI/LO hold their old values until commit.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    logic [31:0] old_hi, old_lo;
    old_hi = hi;
    old_lo = lo;
    @(negedge clk);
    start = 1'b1; mdu_type = op; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0; mdu_type = 4'd0;
    cycles = 0;
    while (busy && cycles < 40) begin
      check("hold_hi", hi, old_hi);
      check("hold_lo", lo, old_lo);
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic check_reads(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    mdu_type = 4'd5; #1;
    check({tag, "_mfhi"}, result, ehi);
    mdu_type = 4'd6; #1;
    check({tag, "_mflo"}, result, elo);
    mdu_type = 4'd0; #1;
    check({tag, "_none"}, result, 32'd0);
  endtask

  initial begin
    int cyc;

    vecs[0] = '{4'd1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 5};
    vecs[1] = '{4'd2, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 5};
    vecs[2] = '{4'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3] = '{4'd4, 32'd7,         32'd2,         32'd1,         32'd3,         10};
    vecs[4] = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 10};
    vecs[5] = '{4'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10};
    vecs[6] = '{4'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 5};
    vecs[7] = '{4'd2, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
    vecs[8] = '{4'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 5};

    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check_reads("rst", 32'd0, 32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
      check($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].cyc));
      check($sformatf("v%0d_hi", i), hi, vecs[i].ehi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].elo);
      check_reads($sformatf("v%0d", i), vecs[i].ehi, vecs[i].elo);
    end

    // MTLO is single cycle; then divide by zero leaves HI/LO alone
    @(negedge clk);
    start = 1'b1; mdu_type = 4'd8; rs_val = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0; mdu_type = 4'd0;
    check("mtlo_lo", lo, 32'h1234_5678);
    check("mtlo_hi", hi, 32'h0000_0000);
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    run_op(4'd3, 32'd5, 32'd0, cyc);
    check("div0_cycles", 32'(cyc), 32'd10);
    check("div0_lo", lo, 32'h1234_5678);
    check("div0_hi", hi, 32'h0000_0000);

    // MTHI accepted normally
    @(negedge clk);
    start = 1'b1; mdu_type = 4'd7; rs_val = 32'hCAFE_0001;
    @(negedge clk);
    start = 1'b0; mdu_type = 4'd0;
    check("mthi_hi", hi, 32'hCAFE_0001);

    // MTHI arriving during busy is ignored; the divide still commits
    @(negedge clk);
    start = 1'b1; mdu_type = 4'd3; rs_val = 32'd17; rt_val = 32'd5;
    @(negedge clk);
    start = 1'b0; mdu_type = 4'd0;
    repeat (2) @(negedge clk);
    start = 1'b1; mdu_type = 4'd7; rs_val = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; mdu_type = 4'd0;
    cyc = 0;
    while (busy && cyc < 40) begin cyc++; @(negedge clk); end
    check("busy_mthi_left", 32'(cyc), 32'd7);
    check("busy_mthi_hi", hi, 32'd2);
    check("busy_mthi_lo", lo, 32'd3);

    // Cancelled MULT and non-starting opcodes do nothing
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; mdu_type = 4'd1; rs_val = 32'd9; rt_val = 32'd9;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; mdu_type = 4'd0;
    check("cancel_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("cancel_hi", hi, 32'd2);
    check("cancel_lo", lo, 32'd3);
    start = 1'b1; mdu_type = 4'd9; rs_val = 32'h5555_5555;
    @(negedge clk);
    mdu_type = 4'd5;
    @(negedge clk);
    start = 1'b0; mdu_type = 4'd0;
    check("badop_busy", {31'd0, busy}, 32'd0);
    check("badop_hi", hi, 32'd2);
    check("badop_lo", lo, 32'd3);

    // Async reset in cycle 4 of a MULT
    @(negedge clk);
    start = 1'b1; mdu_type = 4'd1; rs_val = 32'd3; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0; mdu_type = 4'd0;
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check_reads("post_rst", 32'd0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Execute-stage multiply/divide unit (MDU) holding the architectural HI/LO registers.
- Consumes the decoder's MDU start strobe and 4-bit MDU operation code, plus operand values forwarded into the E stage.
- Models multi-cycle MULT/DIV latency with a busy counter, which the hazard unit uses to stall.
- Services MFHI/MFLO reads combinationally and MTHI/MTLO writes in a single cycle.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for MULT/MULTU. Legal range 1..15.
- DIV_CYCLES, 10, busy duration in cycles for DIV/DIVU. Legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  reset: one clock; reset is asynchronous and active-low.
- start  input  1  operation strobe from the decoder; asserted for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- mdu_type  input  4  operation code: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO.
- cancel  input  1  exception/flush in a later stage; kills any start sampled this cycle.
- rs_val  input  32  operand A (dividend / multiplicand / MT source).
- rt_val  input  32  operand B (divisor / multiplier).
- busy  output  1  high while a MULT/DIV is in flight; registered.
- hi  output  32  architectural HI.
- lo  output  32  architectural LO.
- result  output  32  read data: hi when mdu_type=5, lo when mdu_type=6, else 0. Combinational from current hi/lo.

Behaviour:
- Reset (async, reset_n=0): hi=0, lo=0, busy=0, cycle counter=0, pending HI/LO=0. Reset asserted mid-operation discards the pending result.
- Accepting an operation:
  - start is accepted at a rising edge only when start=1, cancel=0, busy=0.
  - start while busy=1 is ignored; hazard logic guarantees this does not occur, but the block must not corrupt state if it does.
  - start with mdu_type outside 1..4 and 7..8 is ignored.
- MULT/MULTU accepted at edge k:
  - Compute the 64-bit product now: signed for MULT, unsigned for MULTU. Store it in pending regs.
  - Load the counter with MULT_CYCLES, so busy=1 after edge k.
- DIV/DIVU accepted at edge k:
  - Quotient goes to pending LO, remainder to pending HI.
  - DIV is signed; quotient truncates toward zero and the remainder takes the dividend's sign.
  - Load the counter with DIV_CYCLES.
  - Divisor 0: the counter still runs the full DIV_CYCLES, but HI/LO are left unchanged at commit.
  - 0x80000000 / -1 (signed): LO=0x80000000, HI=0.
- Counter and commit:
  - The counter decrements at each edge while nonzero.
  - At the edge where it goes 1->0, pending is committed to hi/lo and busy falls.
  - Thus busy is high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES), and new hi/lo are visible in the cycle after busy falls.
- MTHI/MTLO accepted at edge k: hi (or lo) <= rs_val at edge k; busy stays 0.
- MFHI/MFLO: no state change. result reflects hi/lo as of the current cycle, no internal bypass. The stall logic holds MF instructions in E while busy or start is high.
- cancel: affects only the start sampled in the same cycle. An operation already in flight is not aborted by cancel and still commits; the exception handler relies on HI/LO being precise for accepted instructions.
- Simultaneous commit and start: cannot occur, since start is ignored while busy=1. A start in the cycle right after busy falls is accepted normally and sees the committed hi/lo.
- Widths: all products are 64-bit, with hi = [63:32] and lo = [31:0]. The counter is 4 bits.

Test Plan:
- Reset then MULT rs=0xFFFFFFFD (-3), rt=5 -> busy high exactly 5 cycles; after the fall, hi=0xFFFFFFFF, lo=0xFFFFFFF1. During busy, hi/lo remain 0.
- MULTU rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles. mdu_type=5 then gives result=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7, rt=2 -> lo=3, hi=1.
- MTLO rs=0x12345678 -> lo updates at the next edge with busy=0. Then DIV rs=5, rt=0 -> busy 10 cycles, lo stays 0x12345678.
- DIV started, then start=1 MTHI asserted at cycle 3 of busy -> ignored, final hi is the remainder. MULT with cancel=1 -> busy stays 0 and hi/lo are unchanged.
- reset_n pulled low at cycle 4 of a MULT -> hi=lo=0 and busy=0 immediately (async). After release, MFLO gives result=0.
